// File: rtl/osc_cfg_pkg.sv
// Shared types and constants for the pixel-clock oscillator configuration sequencer:
// FSM states, the FWVGA register table and the default oscillator slave address.
package osc_cfg_pkg;

    typedef enum logic [2:0] {
        PWR_WAIT,
        ISSUE,
        WAIT_RSP,
        SETTLE,
        DONE,
        FAIL
    } cfg_state_e;

    typedef struct packed {
        logic [7:0] reg_addr;
        logic [7:0] data;
    } cfg_entry_t;

    localparam int unsigned TABLE_LEN      = 11;
    localparam logic [6:0]  OSC_SLAVE_ADDR = 7'h55;

    localparam cfg_entry_t OSC_TABLE [TABLE_LEN] = '{
        '{8'h84, 8'h00}, '{8'h00, 8'h23}, '{8'h05, 8'hB0}, '{8'h06, 8'h0B},
        '{8'h07, 8'h89}, '{8'h08, 8'h58}, '{8'h09, 8'h08}, '{8'h0A, 8'h44},
        '{8'h0B, 8'h00}, '{8'h84, 8'h01}, '{8'h84, 8'h04}
    };

    // Indices past the end of the table read as zero instead of running off the array.
    function automatic cfg_entry_t table_entry(input logic [3:0] idx);
        if (idx < 4'(TABLE_LEN)) begin
            return OSC_TABLE[idx];
        end
        return '0;
    endfunction

endpackage

// File: rtl/osc_cfg_sequencer_if.sv
// Command/response handshake between the oscillator config sequencer (master)
// and the I2C byte-write engine (slave).
interface osc_cfg_sequencer_if;
    logic       CMD_VALID;
    logic       CMD_READY;
    logic [6:0] CMD_SLAVE;
    logic [7:0] CMD_REG;
    logic [7:0] CMD_DATA;
    logic       RSP_VALID;
    logic       RSP_NACK;

    modport master (
        output CMD_VALID, CMD_SLAVE, CMD_REG, CMD_DATA,
        input  CMD_READY, RSP_VALID, RSP_NACK
    );

    modport slave (
        input  CMD_VALID, CMD_SLAVE, CMD_REG, CMD_DATA,
        output CMD_READY, RSP_VALID, RSP_NACK
    );
endinterface

// File: rtl/cfg_delay_timer.sv
// 32-bit up-counting delay timer: load restarts from zero, en counts up to limit_i,
// expire_o is high once the count is no longer below limit_i.
module cfg_delay_timer (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic        en_i,
    input  logic [31:0] limit_i,
    output logic        expire_o
);
    logic [31:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= '0;
        end else if (en_i && (cnt_q < limit_i)) begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

    assign expire_o = !(cnt_q < limit_i);

endmodule

// File: rtl/osc_cfg_sequencer.sv
// Power-on write sequencer for the pixel-clock oscillator; walks the register table
// over the I2C command handshake. Define CFG_WATCHDOG_EN to add a WAIT_RSP timeout.
//
// state    | meaning
// PWR_WAIT | power-on delay before the first command
// ISSUE    | CMD_VALID high with table[index], waiting for CMD_READY
// WAIT_RSP | command accepted, waiting for ACK/NACK
// SETTLE   | all entries ACKed, settle delay running
// DONE     | CFG_DONE held until reset
// FAIL     | retries exhausted, CFG_FAIL held until reset
module osc_cfg_sequencer
    import osc_cfg_pkg::*;
#(
    parameter int unsigned POWERUP_DELAY = 90000000,
    parameter int unsigned SETTLE_DELAY  = 150000000,
    parameter int unsigned NUM_REGS      = 11,
    parameter int unsigned MAX_RETRY     = 3,
    parameter logic [6:0]  SLAVE_ADDR    = OSC_SLAVE_ADDR
`ifdef CFG_WATCHDOG_EN
    ,
    parameter int unsigned RSP_TIMEOUT   = 4000
`endif
) (
    input  logic                       CLOCK_IN,
    input  logic                       RESET,
    osc_cfg_sequencer_if.master        cmd_if,
    output logic                       CFG_BUSY,
    output logic                       CFG_DONE,
    output logic                       CFG_FAIL,
    output logic [7:0]                 STATUS_LED
);

    cfg_state_e  state_q;
    logic [3:0]  idx_q;
    logic [3:0]  retry_q;
    logic        cmd_valid_q;
    logic [6:0]  slave_q;
    logic [7:0]  reg_q;
    logic [7:0]  data_q;
    logic        busy_q;
    logic        done_q;
    logic        fail_q;

    logic        tmr_load;
    logic        tmr_en;
    logic        tmr_expire;
    logic [31:0] tmr_limit;
    logic        rsp_ack;
    logic        rsp_bad;
    cfg_entry_t  cur_entry;
    cfg_entry_t  next_entry;

    assign cur_entry  = table_entry(idx_q);
    assign next_entry = table_entry(idx_q + 4'd1);

    // The timer is cleared while a command is pending and on any response, so it
    // starts from zero on entry to both WAIT_RSP and SETTLE.
    always_comb begin
        tmr_load  = 1'b0;
        tmr_en    = 1'b0;
        tmr_limit = 32'(POWERUP_DELAY - 1);
        case (state_q)
            PWR_WAIT: tmr_en = 1'b1;
            ISSUE:    tmr_load = 1'b1;
            WAIT_RSP: begin
                tmr_load = cmd_if.RSP_VALID;
`ifdef CFG_WATCHDOG_EN
                tmr_en    = 1'b1;
                tmr_limit = 32'(RSP_TIMEOUT - 1);
`endif
            end
            SETTLE: begin
                tmr_en    = 1'b1;
                tmr_limit = 32'(SETTLE_DELAY - 1);
            end
            default: ;
        endcase
    end

    assign rsp_ack = cmd_if.RSP_VALID && !cmd_if.RSP_NACK;
`ifdef CFG_WATCHDOG_EN
    assign rsp_bad = cmd_if.RSP_VALID ? cmd_if.RSP_NACK : tmr_expire;
`else
    assign rsp_bad = cmd_if.RSP_VALID && cmd_if.RSP_NACK;
`endif

    cfg_delay_timer u_timer (
        .clk_i    (CLOCK_IN),
        .rst_i    (RESET),
        .load_i   (tmr_load),
        .en_i     (tmr_en),
        .limit_i  (tmr_limit),
        .expire_o (tmr_expire)
    );

    always_ff @(posedge CLOCK_IN) begin
        if (RESET) begin
            state_q     <= PWR_WAIT;
            idx_q       <= '0;
            retry_q     <= '0;
            cmd_valid_q <= 1'b0;
            slave_q     <= '0;
            reg_q       <= '0;
            data_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            case (state_q)
                PWR_WAIT: begin
                    busy_q  <= 1'b1;
                    slave_q <= SLAVE_ADDR;
                    if (tmr_expire) begin
                        state_q     <= ISSUE;
                        cmd_valid_q <= 1'b1;
                        reg_q       <= cur_entry.reg_addr;
                        data_q      <= cur_entry.data;
                    end
                end
                ISSUE: begin
                    if (cmd_valid_q && cmd_if.CMD_READY) begin
                        state_q     <= WAIT_RSP;
                        cmd_valid_q <= 1'b0;
                    end
                end
                WAIT_RSP: begin
                    if (rsp_ack) begin
                        retry_q <= '0;
                        idx_q   <= idx_q + 4'd1;
                        if (idx_q == 4'(NUM_REGS - 1)) begin
                            state_q <= SETTLE;
                        end else begin
                            state_q     <= ISSUE;
                            cmd_valid_q <= 1'b1;
                            reg_q       <= next_entry.reg_addr;
                            data_q      <= next_entry.data;
                        end
                    end else if (rsp_bad) begin
                        if (retry_q < 4'(MAX_RETRY)) begin
                            retry_q     <= retry_q + 4'd1;
                            state_q     <= ISSUE;
                            cmd_valid_q <= 1'b1;
                        end else begin
                            state_q <= FAIL;
                            fail_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                SETTLE: begin
                    if (tmr_expire) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cmd_if.CMD_VALID = cmd_valid_q;
    assign cmd_if.CMD_SLAVE = slave_q;
    assign cmd_if.CMD_REG   = reg_q;
    assign cmd_if.CMD_DATA  = data_q;
    assign CFG_BUSY         = busy_q;
    assign CFG_DONE         = done_q;
    assign CFG_FAIL         = fail_q;
    assign STATUS_LED       = {idx_q, retry_q};

endmodule

// File: tb/tb_osc_cfg_sequencer.sv
// Directed bench for osc_cfg_sequencer with short delays (POWERUP 20, SETTLE 10, 3 retries).
module tb_osc_cfg_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       busy, done, fail;
    logic [7:0] led;
    int         cyc = 0;
    int         acc_cnt = 0;
    int         rel = 0;
    int         checks = 0;
    int         errors = 0;

    logic [7:0] exp_reg [11] = '{8'h84, 8'h00, 8'h05, 8'h06, 8'h07, 8'h08,
                                 8'h09, 8'h0A, 8'h0B, 8'h84, 8'h84};
    logic [7:0] exp_dat [11] = '{8'h00, 8'h23, 8'hB0, 8'h0B, 8'h89, 8'h58,
                                 8'h08, 8'h44, 8'h00, 8'h01, 8'h04};

    osc_cfg_sequencer_if cmd_if ();

    osc_cfg_sequencer #(
        .POWERUP_DELAY (20),
        .SETTLE_DELAY  (10),
        .NUM_REGS      (11),
        .MAX_RETRY     (3),
        .SLAVE_ADDR    (7'h55)
`ifdef CFG_WATCHDOG_EN
        ,
        .RSP_TIMEOUT   (30)
`endif
    ) dut (
        .CLOCK_IN   (clk),
        .RESET      (rst),
        .cmd_if     (cmd_if),
        .CFG_BUSY   (busy),
        .CFG_DONE   (done),
        .CFG_FAIL   (fail),
        .STATUS_LED (led)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cmd_if.CMD_VALID === 1'b1 && cmd_if.CMD_READY === 1'b1) acc_cnt <= acc_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input string t);
        rst = 1'b1;
        cmd_if.RSP_VALID = 1'b0;
        cmd_if.RSP_NACK  = 1'b0;
        repeat (3) @(negedge clk);
        chk({t, "_rst_valid"}, 32'(cmd_if.CMD_VALID), 32'd0);
        chk({t, "_rst_slave"}, 32'(cmd_if.CMD_SLAVE), 32'd0);
        chk({t, "_rst_flags"}, 32'({busy, done, fail}), 32'd0);
        chk({t, "_rst_led"}, 32'(led), 32'd0);
        rst = 1'b0;
        rel = cyc;
    endtask

    // Waits for the first command after reset release and checks its latency and content.
    task automatic wait_first(input string t);
        int n;
        @(negedge clk);
        chk({t, "_busy_early"}, 32'(busy), 32'd1);
        chk({t, "_slave"}, 32'(cmd_if.CMD_SLAVE), 32'h55);
        n = 0;
        while (cmd_if.CMD_VALID !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({t, "_first_latency"}, 32'(cyc - rel), 32'd20);
        chk({t, "_first_reg"}, 32'(cmd_if.CMD_REG), 32'h84);
        chk({t, "_first_data"}, 32'(cmd_if.CMD_DATA), 32'h00);
    endtask

    // One command with CMD_READY high: accepted on the next edge, response 5 cycles later.
    task automatic do_entry(input int i, input logic nack, input logic [7:0] exp_led,
                            input logic exp_v);
        int n;
        n = 0;
        while (cmd_if.CMD_VALID !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("e%0d_valid_seen", i), 32'(n < 200), 32'd1);
        chk($sformatf("e%0d_reg", i), 32'(cmd_if.CMD_REG), 32'(exp_reg[i]));
        chk($sformatf("e%0d_data", i), 32'(cmd_if.CMD_DATA), 32'(exp_dat[i]));
        @(negedge clk);
        chk($sformatf("e%0d_valid_drop", i), 32'(cmd_if.CMD_VALID), 32'd0);
        repeat (4) @(negedge clk);
        cmd_if.RSP_VALID = 1'b1;
        cmd_if.RSP_NACK  = nack;
        @(negedge clk);
        cmd_if.RSP_VALID = 1'b0;
        cmd_if.RSP_NACK  = 1'b0;
        chk($sformatf("e%0d_next_valid", i), 32'(cmd_if.CMD_VALID), 32'(exp_v));
        chk($sformatf("e%0d_led", i), 32'(led), 32'(exp_led));
    endtask

    initial begin
        int t0, n, a0, bad;
        int tw [4];
        cmd_if.CMD_READY = 1'b1;
        cmd_if.RSP_VALID = 1'b0;
        cmd_if.RSP_NACK  = 1'b0;

        // 1: clean run through the whole table
        do_reset("t1");
        wait_first("t1");
        for (int i = 0; i < 11; i++) do_entry(i, 1'b0, 8'((i + 1) << 4), i != 10);
        t0 = cyc;
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("t1_done_latency", 32'(cyc - t0), 32'd10);
        chk("t1_fail", 32'(fail), 32'd0);
        chk("t1_busy", 32'(busy), 32'd0);
        chk("t1_led", 32'(led), 32'hB0);
        repeat (5) @(negedge clk);
        chk("t1_done_sticky", 32'(done), 32'd1);

        // 2: entry 2 NACKed twice, then ACKed
        do_reset("t2");
        wait_first("t2");
        for (int i = 0; i < 11; i++) begin
            if (i == 2) begin
                do_entry(2, 1'b1, 8'h21, 1'b1);
                do_entry(2, 1'b1, 8'h22, 1'b1);
            end
            do_entry(i, 1'b0, 8'((i + 1) << 4), i != 10);
        end
        repeat (12) @(negedge clk);
        chk("t2_done", 32'(done), 32'd1);
        chk("t2_fail", 32'(fail), 32'd0);

        // 3: entry 4 NACKed four times -> FAIL
        do_reset("t3");
        wait_first("t3");
        for (int i = 0; i < 4; i++) do_entry(i, 1'b0, 8'((i + 1) << 4), 1'b1);
        a0 = acc_cnt;
        do_entry(4, 1'b1, 8'h41, 1'b1);
        do_entry(4, 1'b1, 8'h42, 1'b1);
        do_entry(4, 1'b1, 8'h43, 1'b1);
        do_entry(4, 1'b1, 8'h43, 1'b0);
        chk("t3_fail", 32'(fail), 32'd1);
        chk("t3_busy", 32'(busy), 32'd0);
        repeat (30) @(negedge clk);
        chk("t3_issues", 32'(acc_cnt - a0), 32'd4);
        chk("t3_valid_held_low", 32'(cmd_if.CMD_VALID), 32'd0);
        chk("t3_done", 32'(done), 32'd0);
        chk("t3_led_idx", 32'(led[7:4]), 32'd4);

        // 4: READY low for 50 cycles; a response coinciding with acceptance is ignored
        cmd_if.CMD_READY = 1'b0;
        do_reset("t4");
        wait_first("t4");
        a0 = acc_cnt;
        bad = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (cmd_if.CMD_VALID !== 1'b1 || cmd_if.CMD_REG !== 8'h84 ||
                cmd_if.CMD_DATA !== 8'h00) bad++;
        end
        chk("t4_stable", 32'(bad), 32'd0);
        chk("t4_no_accept", 32'(acc_cnt - a0), 32'd0);
        cmd_if.CMD_READY = 1'b1;
        cmd_if.RSP_VALID = 1'b1;
        cmd_if.RSP_NACK  = 1'b1;
        @(negedge clk);
        cmd_if.RSP_VALID = 1'b0;
        cmd_if.RSP_NACK  = 1'b0;
        chk("t4_valid_drop", 32'(cmd_if.CMD_VALID), 32'd0);
        chk("t4_one_accept", 32'(acc_cnt - a0), 32'd1);
        repeat (8) @(negedge clk);
        chk("t4_no_reissue", 32'(cmd_if.CMD_VALID), 32'd0);
        chk("t4_retry_clear", 32'(led), 32'h00);
        chk("t4_still_one", 32'(acc_cnt - a0), 32'd1);
        cmd_if.RSP_VALID = 1'b1;
        @(negedge clk);
        cmd_if.RSP_VALID = 1'b0;
        chk("t4_next_valid", 32'(cmd_if.CMD_VALID), 32'd1);
        chk("t4_next_reg", 32'(cmd_if.CMD_REG), 32'h00);
        chk("t4_next_data", 32'(cmd_if.CMD_DATA), 32'h23);
        chk("t4_led", 32'(led), 32'h10);

        // 5: reset during entry 6 WAIT_RSP, then a late response
        do_reset("t5");
        wait_first("t5");
        for (int i = 0; i < 6; i++) do_entry(i, 1'b0, 8'((i + 1) << 4), 1'b1);
        n = 0;
        while (cmd_if.CMD_VALID !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("t5_e6_reg", 32'(cmd_if.CMD_REG), 32'h09);
        @(negedge clk);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_zero_valid", 32'(cmd_if.CMD_VALID), 32'd0);
        chk("t5_zero_regdata", 32'({cmd_if.CMD_REG, cmd_if.CMD_DATA}), 32'd0);
        chk("t5_zero_slave", 32'(cmd_if.CMD_SLAVE), 32'd0);
        chk("t5_zero_flags", 32'({busy, done, fail}), 32'd0);
        chk("t5_zero_led", 32'(led), 32'd0);
        rst = 1'b0;
        rel = cyc;
        cmd_if.RSP_VALID = 1'b1;
        cmd_if.RSP_NACK  = 1'b0;
        @(negedge clk);
        cmd_if.RSP_VALID = 1'b0;
        chk("t5_led_after_late", 32'(led), 32'd0);
        n = 0;
        while (cmd_if.CMD_VALID !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("t5_restart_latency", 32'(cyc - rel), 32'd20);
        chk("t5_restart_reg", 32'(cmd_if.CMD_REG), 32'h84);
        chk("t5_restart_data", 32'(cmd_if.CMD_DATA), 32'h00);
        chk("t5_restart_led", 32'(led), 32'h00);

`ifdef CFG_WATCHDOG_EN
        // 6: no response at all on entry 1 -> reissue on timeout, then FAIL
        do_reset("t6");
        wait_first("t6");
        do_entry(0, 1'b0, 8'h10, 1'b1);
        a0 = acc_cnt;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (cmd_if.CMD_VALID !== 1'b1 && n < 100) begin
                @(negedge clk);
                n++;
            end
            tw[k] = cyc;
            chk($sformatf("t6_reg%0d", k), 32'(cmd_if.CMD_REG), 32'h00);
            chk($sformatf("t6_data%0d", k), 32'(cmd_if.CMD_DATA), 32'h23);
            @(negedge clk);
        end
        for (int k = 1; k < 4; k++)
            chk($sformatf("t6_gap%0d", k), 32'(tw[k] - tw[k-1]), 32'd31);
        repeat (40) @(negedge clk);
        chk("t6_issues", 32'(acc_cnt - a0), 32'd4);
        chk("t6_fail", 32'(fail), 32'd1);
        chk("t6_valid", 32'(cmd_if.CMD_VALID), 32'd0);
        chk("t6_led", 32'(led), 32'h13);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
